// File: rtl/proc_pkg.sv
// Shared constants for the simple processor: opcodes, control-FSM states and
// default datapath sizing.
package proc_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_NREG   = 8;

    localparam logic [1:0] OP_MV  = 2'b00;
    localparam logic [1:0] OP_MVI = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

endpackage

// File: rtl/proc_ctrl_regn.sv
// Generic W-bit register with synchronous active-high reset and load enable.
// Reset takes priority over load, so an aborted instruction never lands.
module regn #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/proc_ctrl.sv
// Control and register stage of the simple processor: fetches instructions,
// sequences mv/mvi/add/sub and feeds the external add/sub unit.
module proc_ctrl
    import proc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREG   = DEF_NREG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] as_s,
    input  logic              as_co,
    output logic [DATA_W-1:0] as_a,
    output logic [DATA_W-1:0] as_b,
    output logic              as_ci,
    output logic [DATA_W-1:0] bus,
    output logic              done,
    output logic              cflag
);

    state_t state_q, state_d;

    logic [DATA_W-1:0] irQ, aQ, gQ;
    logic [DATA_W-1:0] regQ [NREG];
    logic [NREG-1:0]   regEn;
    logic [1:0]        opcode;
    logic [2:0]        rx, ry;
    logic              isMove, writeBack;
    logic              irEn, aEn, gEn;

    assign opcode = irQ[7:6];
    assign rx     = irQ[5:3];
    assign ry     = irQ[2:0];
    assign isMove = (opcode == OP_MV) || (opcode == OP_MVI);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= T0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            T0:      state_d = run ? T1 : T0;
            T1:      state_d = isMove ? T0 : T2;
            T2:      state_d = T3;
            T3:      state_d = T0;
            default: state_d = T0;
        endcase
    end

    // Every register write-back goes through the bus, so one enable decode covers mv, mvi and T3.
    assign writeBack = ((state_q == T1) && isMove) || (state_q == T3);
    assign irEn      = (state_q == T0) && run;
    assign aEn       = (state_q == T1) && !isMove;
    assign gEn       = (state_q == T2);

    always_comb begin
        regEn = '0;
        if (writeBack) begin
            regEn[rx] = 1'b1;
        end
    end

    always_comb begin
        bus = '0;
        case (state_q)
            T1: begin
                if (opcode == OP_MV) begin
                    bus = regQ[ry];
                end else if (opcode == OP_MVI) begin
                    bus = din;
                end else begin
                    bus = regQ[rx];
                end
            end
            T2:      bus = regQ[ry];
            T3:      bus = gQ;
            default: bus = '0;
        endcase
    end

    for (genvar i = 0; i < NREG; i++) begin : gReg
        regn #(.W(DATA_W)) uReg (
            .clk   (clk),
            .reset (reset),
            .en_i  (regEn[i]),
            .d_i   (bus),
            .q_o   (regQ[i])
        );
    end

    regn #(.W(DATA_W)) uIr (
        .clk (clk), .reset (reset), .en_i (irEn), .d_i (din), .q_o (irQ)
    );

    regn #(.W(DATA_W)) uA (
        .clk (clk), .reset (reset), .en_i (aEn), .d_i (bus), .q_o (aQ)
    );

    regn #(.W(DATA_W)) uG (
        .clk (clk), .reset (reset), .en_i (gEn), .d_i (as_s), .q_o (gQ)
    );

    regn #(.W(1)) uCflag (
        .clk (clk), .reset (reset), .en_i (gEn), .d_i (as_co), .q_o (cflag)
    );

    // Masking with reset keeps done low when the final cycle of an instruction is aborted.
    assign done  = writeBack && !reset;
    assign as_a  = aQ;
    assign as_b  = bus;
    assign as_ci = (state_q == T2) && irQ[6];

endmodule

// File: tb/tb_proc_ctrl.sv
// Self-checking bench for proc_ctrl: directed scenarios plus random instruction
// streams, checked against an instruction-level register-file model.
module tb_proc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [7:0] din;
    logic [7:0] as_s;
    logic       as_co;
    logic [7:0] as_a;
    logic [7:0] as_b;
    logic       as_ci;
    logic [7:0] bus;
    logic       done;
    logic       cflag;

    logic [8:0] sumFull;

    int testsRun = 0;
    int testsFailed = 0;

    logic [7:0] mReg [8];
    logic [7:0] mA;
    logic       mCflag;

    always #5 clk = ~clk;

    // Stand-in for the external combinational add/sub unit.
    assign sumFull = {1'b0, as_a} + {1'b0, (as_ci ? ~as_b : as_b)} + {8'd0, as_ci};
    assign as_s    = sumFull[7:0];
    assign as_co   = sumFull[8];

    proc_ctrl #(.DATA_W(8), .NREG(8)) dut (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .din   (din),
        .as_s  (as_s),
        .as_co (as_co),
        .as_a  (as_a),
        .as_b  (as_b),
        .as_ci (as_ci),
        .bus   (bus),
        .done  (done),
        .cflag (cflag)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) mReg[i] = 8'h00;
        mA = 8'h00;
        mCflag = 1'b0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Execute one instruction from T0 and check every cycle against the model.
    task automatic applyStimulus(input logic [1:0] op, input int rx, input int ry,
                                 input logic [7:0] imm, input bit pokeRun);
        logic [7:0] opA, opB, result;
        logic       carry;
        opA = mReg[rx];
        opB = mReg[ry];

        run = 1'b1;
        din = {op, 3'(rx), 3'(ry)};
        @(negedge clk);
        checkOutput("t0_bus", bus, 8'h00);
        checkOutput("t0_done", done, 1'b0);
        nextCycle();

        run = 1'b0;
        din = (op == 2'b01) ? imm : 8'h00;
        @(negedge clk);
        checkOutput("t1_as_ci", as_ci, 1'b0);
        checkOutput("t1_cflag", cflag, mCflag);
        checkOutput("t1_as_a", as_a, mA);
        if (op == 2'b00) begin
            checkOutput("mv_bus", bus, opB);
            checkOutput("mv_done", done, 1'b1);
            mReg[rx] = opB;
            nextCycle();
        end else if (op == 2'b01) begin
            checkOutput("mvi_bus", bus, imm);
            checkOutput("mvi_done", done, 1'b1);
            mReg[rx] = imm;
            nextCycle();
        end else begin
            checkOutput("arith_t1_bus", bus, opA);
            checkOutput("arith_t1_done", done, 1'b0);
            mA = opA;
            nextCycle();

            run = pokeRun;
            din = 8'($urandom);
            @(negedge clk);
            checkOutput("t2_bus", bus, opB);
            checkOutput("t2_as_a", as_a, opA);
            checkOutput("t2_as_b", as_b, opB);
            checkOutput("t2_as_ci", as_ci, (op == 2'b11));
            checkOutput("t2_done", done, 1'b0);
            if (op == 2'b10) begin
                result = 8'((int'(opA) + int'(opB)) % 256);
                carry  = (int'(opA) + int'(opB)) > 255;
            end else begin
                result = 8'((int'(opA) - int'(opB) + 256) % 256);
                carry  = opA >= opB;
            end
            nextCycle();

            run = 1'b0;
            din = 8'h00;
            @(negedge clk);
            checkOutput("t3_bus", bus, result);
            checkOutput("t3_done", done, 1'b1);
            checkOutput("t3_cflag", cflag, carry);
            checkOutput("t3_as_ci", as_ci, 1'b0);
            mReg[rx] = result;
            mCflag = carry;
            nextCycle();
        end
    endtask

    task automatic idleCycles(input int n);
        run = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput("idle_bus", bus, 8'h00);
            checkOutput("idle_done", done, 1'b0);
            nextCycle();
        end
    endtask

    // mv Rk <- Rk exposes Rk on the bus without changing any state.
    task automatic readReg(input int k, input logic [7:0] expected);
        run = 1'b1;
        din = {2'b00, 3'(k), 3'(k)};
        nextCycle();
        run = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("reg_R%0d", k), bus, expected);
        nextCycle();
    endtask

    initial begin
        reset = 1'b1;
        run   = 1'b0;
        din   = 8'h00;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_bus", bus, 8'h00);
        checkOutput("rst_as_a", as_a, 8'h00);
        checkOutput("rst_as_b", as_b, 8'h00);
        checkOutput("rst_as_ci", as_ci, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_cflag", cflag, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;

        applyStimulus(2'b01, 0, 0, 8'h05, 1'b0);
        readReg(0, 8'h05);
        applyStimulus(2'b00, 1, 0, 8'h00, 1'b0);
        readReg(1, 8'h05);

        applyStimulus(2'b01, 0, 0, 8'hF0, 1'b0);
        applyStimulus(2'b01, 1, 0, 8'h20, 1'b0);
        applyStimulus(2'b10, 0, 1, 8'h00, 1'b1);
        idleCycles(3);
        readReg(0, 8'h10);
        checkOutput("add_cflag_const", cflag, 1'b1);

        applyStimulus(2'b01, 2, 0, 8'h03, 1'b0);
        applyStimulus(2'b01, 3, 0, 8'h05, 1'b0);
        applyStimulus(2'b11, 2, 3, 8'h00, 1'b0);
        readReg(2, 8'hFE);
        checkOutput("sub_cflag_const", cflag, 1'b0);

        applyStimulus(2'b10, 4, 4, 8'h00, 1'b0);

        for (int n = 0; n < 60; n++) begin
            applyStimulus(2'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        // Abort a sub in T2 by reset.
        applyStimulus(2'b01, 5, 0, 8'h01, 1'b0);
        applyStimulus(2'b01, 6, 0, 8'h09, 1'b0);
        run = 1'b1;
        din = 8'hEE;
        nextCycle();
        run = 1'b0;
        din = 8'h00;
        nextCycle();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_t2_done", done, 1'b0);
        nextCycle();
        reset = 1'b0;
        modelReset();
        @(negedge clk);
        checkOutput("abort_bus", bus, 8'h00);
        checkOutput("abort_done", done, 1'b0);
        checkOutput("abort_cflag", cflag, 1'b0);
        checkOutput("abort_as_a", as_a, 8'h00);
        idleCycles(2);
        for (int k = 0; k < 8; k++) readReg(k, 8'h00);

        for (int n = 0; n < 30; n++) begin
            applyStimulus(2'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        for (int k = 0; k < 8; k++) readReg(k, mReg[k]);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
